// File: rtl/icache_assoc_pkg.sv
// icache_assoc_pkg: shared types and address-split helpers for the
// set-associative instruction cache.
//   icache_state_e : cache controller state (IDLE lookup / FILL from memory)
//   log2c          : ceil(log2(n)), 0 for n == 1
//   nz             : width guard, turns a zero-width field into one bit
//   wo_bits        : word-offset width of a fetch address
//   ix_bits        : set-index width of a fetch address
//   tag_bits       : tag width (word address bits left above offset+index)
package icache_assoc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_e;

  function automatic int unsigned log2c(input int unsigned n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  function automatic int unsigned nz(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int unsigned wo_bits(input int unsigned blkwords);
    return log2c(blkwords);
  endfunction

  function automatic int unsigned ix_bits(input int unsigned sets);
    return log2c(sets);
  endfunction

  // Byte offset [1:0] is never part of the tag, hence 30 word-address bits.
  function automatic int unsigned tag_bits(input int unsigned sets,
                                           input int unsigned blkwords);
    return 30 - log2c(blkwords) - log2c(sets);
  endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// icache_assoc_if: fetch-side and memory-side signals of the instruction cache.
//   Fetch side : imemREN, imemaddr, halt, iflush (to cache); ihit, imemload (from cache)
//   Memory side: iREN, iaddr (from cache); iload, iwait (to cache)
// Handshake semantics:
//   - Fetch: imemREN is a request level. A word is delivered in any cycle where
//     ihit=1; imemload is only meaningful (and is otherwise 0) in that cycle.
//   - Memory: iREN/iaddr are held stable by the cache until the word is taken.
//     A word transfers on every rising edge where iREN=1 and iwait=0; while
//     iwait=1 the request stays pending and iload is ignored.
// The slave modport is the cache's view; master is the environment's view.
interface icache_assoc_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        halt;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  modport slave (
    input  imemREN, imemaddr, halt, iflush, iload, iwait,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, halt, iflush, iload, iwait,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_assoc_lru.sv
// icache_assoc_lru: per-set age-based LRU state for the instruction cache.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (ages = way index)
//   clr_i         : reset all ages to their way index (cache flush)
//   acc_i         : record an access to way acc_way_i of set acc_set_i
//   vic_set_i     : set whose replacement victim is requested
//   vic_valid_i   : valid bits of that set
//   vic_way_o     : lowest invalid way, else the oldest way
// Ages of one set always form a permutation of 0..WAYS-1, so the oldest way
// is unique. WAYS=1 keeps no state.
module icache_assoc_lru
  import icache_assoc_pkg::*;
#(
  parameter  int unsigned SETS = 8,
  parameter  int unsigned WAYS = 2,
  localparam int unsigned SW   = nz(log2c(SETS)),
  localparam int unsigned WW   = nz(log2c(WAYS))
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            acc_i,
  input  logic [SW-1:0]   acc_set_i,
  input  logic [WW-1:0]   acc_way_i,
  input  logic [SW-1:0]   vic_set_i,
  input  logic [WAYS-1:0] vic_valid_i,
  output logic [WW-1:0]   vic_way_o
);

  if (WAYS == 1) begin : g_direct
    logic unused_lru;
    assign unused_lru = ^{clk, rst, clr_i, acc_i, acc_set_i, acc_way_i,
                          vic_set_i, vic_valid_i};
    assign vic_way_o  = '0;
  end else begin : g_assoc
    logic [WW-1:0] age_q [SETS][WAYS];
    logic [WW-1:0] old_age;
    logic [WW-1:0] max_age;
    logic [WW-1:0] vic_way;

    assign old_age = age_q[acc_set_i][acc_way_i];

    // Accessed way becomes youngest; only ways younger than it age by one,
    // which keeps the set's ages a permutation.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            age_q[s][w] <= WW'(w);
      end else if (clr_i) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            age_q[s][w] <= WW'(w);
      end else if (acc_i) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WW'(w) == acc_way_i)
            age_q[acc_set_i][w] <= '0;
          else if (age_q[acc_set_i][w] < old_age)
            age_q[acc_set_i][w] <= age_q[acc_set_i][w] + 1'b1;
        end
      end
    end

    // Oldest way first, then overridden by the lowest-index invalid way
    // (descending scan leaves the lowest one last).
    always_comb begin
      vic_way = '0;
      max_age = age_q[vic_set_i][0];
      for (int w = 1; w < WAYS; w++) begin
        if (age_q[vic_set_i][w] > max_age) begin
          max_age = age_q[vic_set_i][w];
          vic_way = WW'(w);
        end
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (!vic_valid_i[w]) vic_way = WW'(w);
      end
    end

    assign vic_way_o = vic_way;
  end

endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache, multi-word blocks, LRU.
// Ports:
//   CLK, RST     : clock (rising edge), asynchronous active-high reset
//   bus          : icache_assoc_if.slave (fetch port + memory read channel)
//   hit_count    : saturating count of lookup hits
//   miss_count   : saturating count of misses
//   dbg_state_o  : controller state, for debug/observation
// Hits return combinationally in IDLE. A miss latches the block address and
// a victim way, then FILL streams BLKWORDS words from memory into the victim.
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int unsigned SETS     = 8,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned BLKWORDS = 2,
  parameter int unsigned CNTW     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  icache_assoc_if.slave     bus,
  output logic [CNTW-1:0]   hit_count,
  output logic [CNTW-1:0]   miss_count,
  output icache_state_e     dbg_state_o
);

  localparam int unsigned WO  = wo_bits(BLKWORDS);
  localparam int unsigned IX  = ix_bits(SETS);
  localparam int unsigned TW  = tag_bits(SETS, BLKWORDS);
  localparam int unsigned WOS = nz(WO);
  localparam int unsigned WW  = nz(log2c(WAYS));

  // Storage. Only valid bits need reset; tag/data are qualified by valid.
  logic [WAYS-1:0] valid_q [SETS];
  logic [TW-1:0]   tag_q   [SETS][WAYS];
  logic [31:0]     data_q  [SETS][WAYS][BLKWORDS];

  // Control state.
  icache_state_e state_q, state_d;
  logic [WOS-1:0] cnt_q, cnt_d;
  logic           flush_pend_q, flush_pend_d;
  logic [29:0]    miss_w_q, miss_w_d;     // block-aligned word address
  logic [WW-1:0]  victim_q, victim_d;

  logic [CNTW-1:0] hit_cnt_q, miss_cnt_q;

  // Address split of the live fetch address and of the latched miss block.
  logic [29:0]    req_w;
  logic [WOS-1:0] req_off;
  logic [IX-1:0]  req_set, fill_set;
  logic [TW-1:0]  req_tag, fill_tag;
  logic           unused_byte;

  assign req_w       = bus.imemaddr[31:2];
  assign unused_byte = ^bus.imemaddr[1:0];
  assign req_off     = WOS'(req_w) & WOS'(BLKWORDS - 1);
  assign req_set     = IX'(req_w >> WO);
  assign req_tag     = TW'(req_w >> (WO + IX));
  assign fill_set    = IX'(miss_w_q >> WO);
  assign fill_tag    = TW'(miss_w_q >> (WO + IX));

  // Tag match across the ways of the addressed set.
  logic          match;
  logic [WW-1:0] hit_way;

  always_comb begin
    match   = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
        match   = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  // A flush in the same cycle suppresses the lookup entirely.
  logic lookup, hit, miss, fill_beat, fill_last, flush_now;

  assign lookup    = (state_q == IDLE) && bus.imemREN && !bus.halt &&
                     !flush_pend_q && !bus.iflush;
  assign hit       = lookup && match;
  assign miss      = lookup && !match;
  assign fill_beat = (state_q == FILL) && !bus.iwait;
  assign fill_last = fill_beat && (cnt_q == WOS'(BLKWORDS - 1));
  // A flush seen during FILL is held until the fill completes, so the memory
  // transaction finishes and the fresh line is discarded with the rest.
  assign flush_now = ((state_q == IDLE) && bus.iflush) ||
                     (fill_last && (flush_pend_q || bus.iflush));

  logic [WW-1:0] vic_way;

  icache_assoc_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk         (CLK),
    .rst         (RST),
    .clr_i       (flush_now),
    .acc_i       (hit || fill_last),
    .acc_set_i   (hit ? req_set : fill_set),
    .acc_way_i   (hit ? hit_way : victim_q),
    .vic_set_i   (req_set),
    .vic_valid_i (valid_q[req_set]),
    .vic_way_o   (vic_way)
  );

  // FSM: state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      miss_w_q     <= '0;
      victim_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      miss_w_q     <= miss_w_d;
      victim_q     <= victim_d;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    miss_w_d     = miss_w_q;
    victim_d     = victim_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          state_d  = FILL;
          cnt_d    = '0;
          miss_w_d = req_w & ~30'(BLKWORDS - 1);
          victim_d = vic_way;
        end
      end
      FILL: begin
        if (bus.iflush) flush_pend_d = 1'b1;
        if (fill_beat)  cnt_d = cnt_q + 1'b1;
        if (fill_last) begin
          state_d      = IDLE;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          bus.ihit     = 1'b1;
          bus.imemload = data_q[req_set][hit_way][req_off];
        end
      end
      FILL: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {miss_w_q | 30'(cnt_q), 2'b00};
      end
      default: ;
    endcase
  end

  // Valid bits: the victim is invalidated on FILL entry so a partly written
  // line can never hit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (flush_now) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (miss) begin
      valid_q[req_set][vic_way] <= 1'b0;
    end else if (fill_last) begin
      valid_q[fill_set][victim_q] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_beat) data_q[fill_set][victim_q][cnt_q] <= bus.iload;
    if (fill_last) tag_q[fill_set][victim_q] <= fill_tag;
  end

  // Saturating debug counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised set-associative instruction cache with multi-word blocks and LRU replacement.
- Sits between the datapath fetch port and the memory-controller instruction channel.
- Hits return in the same cycle. Misses fill a whole block word-by-word from memory.
- Adds a whole-cache invalidate and hit/miss counters for debug.

Parameters:
- SETS, 8, number of sets; power of 2, ≥2.
- WAYS, 2, associativity; power of 2, 1..8.
- BLKWORDS, 2, 32-bit words per block; power of 2, 1..8.
- CNTW, 32, width of hit/miss counters.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- halt  in  1  CPU halted; new lookups and new misses are suppressed.
- iflush  in  1  one-cycle pulse: invalidate all lines.
- ihit  out  1  fetch data valid this cycle.
- imemload  out  32  instruction word; 0 when ihit=0.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iload  in  32  memory read data.
- iwait  in  1  memory busy; data is valid when low while iREN=1.
- hit_count  out  CNTW  saturating count of hits.
- miss_count  out  CNTW  saturating count of misses.

Behaviour:
- Reset is asynchronous and active-high. All valid bits = 0, LRU ages = way index, state = IDLE, counters = 0, flush_pend = 0.
- Outputs at reset: ihit=0, imemload=0, iREN=0, iaddr=0.
- Address split: byte [1:0], word offset WO=log2(BLKWORDS) bits, index IX=log2(SETS) bits, tag = remaining upper bits.
- Default split: word bit [2], index [5:3], tag [31:6].
- Lookup is combinational in IDLE. Condition: imemREN & !halt & !flush_pend, and some way has valid & tag match.
  - On a hit: ihit=1, imemload = data[set][way][wordoff] in the same cycle.
  - On a hit: hit_count+1 on that edge, and the LRU is updated (hit way becomes MRU).
- Miss (lookup with no match): latch the miss address, pick a victim, go to FILL next cycle, miss_count+1 once per miss.
- Victim choice: lowest-index invalid way; otherwise the way with maximum age.
- LRU uses per-way age of log2(WAYS) bits. On access, the accessed way's age = 0, and ways younger than its old age +1. WAYS=1 has no LRU state.
- FILL state:
  - Outputs: iREN=1, iaddr = {latched tag, index, cnt, 2'b00}, with cnt starting at 0.
  - Each cycle with iwait=0: write iload into victim data[cnt], cnt+1.
  - After the last word: set valid, write the tag, update LRU (victim becomes MRU), go to IDLE.
  - The following IDLE cycle hits if the address is unchanged.
  - Miss penalty = 1 + Σ(per-word wait + 1) cycles. ihit=0 throughout FILL.
- Address changes, imemREN drops, or halt rises during FILL: the fill completes on the latched address; memory transactions are never abandoned.
- The victim line's valid bit is cleared on FILL entry, so a partial line is never hit.
- iflush in IDLE clears all valid bits and resets LRU at the next edge. ihit is forced to 0 in the iflush cycle.
- iflush during FILL sets flush_pend. The flush is applied on the FILL→IDLE edge, and the just-filled line is also invalidated.
- halt=1 in IDLE: ihit=0, no miss, counters frozen.
- Counters saturate at all-ones; they do not wrap.
- Simultaneous hit and iflush: the flush wins; no hit is counted.
- States: IDLE, FILL. Only this state and cnt are sequential control.

Decomposition:
- Shared package (cpu_types_pkg) holds:
  - the address-split helper constants: offset/index/tag widths derived from the parameters;
  - the state enum;
  - the icache line struct: valid, tag, data[BLKWORDS].
- One natural sub-module, icache_lru: per-set age array with access/victim/reset ports, parametrised by SETS and WAYS.

Test Plan:
- Cold miss: RST, then fetch 0x0000_0040 with iwait=0 for 1 cycle per word.
  - Required: iaddr 0x40 then 0x44, iREN high for 2 fill cycles.
  - Required: next cycle ihit=1 with imemload=word0; fetch 0x44 hits immediately.
  - Required: miss_count=1, hit_count=2.
- Associativity/LRU:
  - Fill 0x040, 0x080 (both set 0) → both hit.
  - Access 0x040, then miss 0x0C0 → 0x080's way is evicted.
  - Required: 0x040 still hits; 0x080 misses.
- Wait states: iwait high for 3 cycles per word.
  - Required: fill lasts 8 cycles and data is correct.
  - Required: imemaddr changed mid-fill → fill still completes on the original block; the new address then misses.
- Flush: iflush in IDLE → all prior lines miss. iflush mid-FILL → fill completes, then that line also misses.
- Halt: halt=1 with a resident address → ihit=0, counters unchanged, iREN=0.
- Reset mid-FILL: RST asserted → iREN=0 immediately (asynchronous), all lines invalid, counters 0.
